// File: rtl/conv_bias_ctrl_if.sv
// Bias-control bus: job registers, bias-load handshake, FIFO pop side and adder status.
// The master side drives the job and load inputs; the slave (controller) drives pops and status.
interface conv_bias_ctrl_if #(
  parameter int CHANNEL_OUT_NUM       = 8,
  parameter int WIDTH_DATA_ADD        = 32,
  parameter int WIDTH_FEATURE_SIZE    = 12,
  parameter int WIDTH_CHANNEL_NUM_REG = 10
);
  logic                                      Start;
  logic [WIDTH_CHANNEL_NUM_REG-1:0]          Channel_Out_Num_REG;
  logic [WIDTH_FEATURE_SIZE-1:0]             Row_Num_Out_REG;
  logic [WIDTH_FEATURE_SIZE-1:0]             S_Count_Fifo;
  logic [WIDTH_DATA_ADD*CHANNEL_OUT_NUM-1:0] Bias_Data;
  logic                                      Bias_Valid;
  logic                                      Bias_Ready;
  logic                                      fifo_ready;
  logic                                      rd_en_fifo;
  logic [WIDTH_DATA_ADD*CHANNEL_OUT_NUM-1:0] bias_data_in;
  logic                                      Next_Reg;
  logic                                      M_Valid;
  logic                                      Done;

  modport master (
    output Start, Channel_Out_Num_REG, Row_Num_Out_REG, S_Count_Fifo,
    output Bias_Data, Bias_Valid, fifo_ready,
    input  Bias_Ready, rd_en_fifo, bias_data_in, Next_Reg, M_Valid, Done
  );

  modport slave (
    input  Start, Channel_Out_Num_REG, Row_Num_Out_REG, S_Count_Fifo,
    input  Bias_Data, Bias_Valid, fifo_ready,
    output Bias_Ready, rd_en_fifo, bias_data_in, Next_Reg, M_Valid, Done
  );
endinterface

// File: rtl/conv_bias_ctrl.sv
// Loads G bias groups, then per burst pops N FIFO words with the matching bias group; M_Valid trails pops by 1+ADD_LATENCY.
// Bias_Valid is held off by Bias_Ready (LOAD only); bursts wait on fifo_ready, which is ignored once a burst starts.
module conv_bias_ctrl #(
  parameter int CHANNEL_OUT_NUM       = 8,
  parameter int WIDTH_DATA_ADD        = 32,
  parameter int WIDTH_FEATURE_SIZE    = 12,
  parameter int WIDTH_CHANNEL_NUM_REG = 10,
  parameter int ADD_LATENCY           = 2
) (
  input logic             clk,
  input logic             rst,
  conv_bias_ctrl_if.slave bus
);
  localparam int GW    = WIDTH_CHANNEL_NUM_REG - 3;
  localparam int DEPTH = 1 << GW;
  localparam int BW    = WIDTH_DATA_ADD * CHANNEL_OUT_NUM;
  localparam int CW    = WIDTH_CHANNEL_NUM_REG;
  localparam int FW    = WIDTH_FEATURE_SIZE;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_READ  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  logic [2:0]         state;
  logic [CW-1:0]      g_num, load_idx, grp_idx, g_in;
  logic [FW-1:0]      r_num, n_num, pop_cnt, burst_cnt;
  logic [3:0]         drain_cnt;
  logic               zero_job;
  logic               next_q;
  logic [ADD_LATENCY:0] mv_pipe;
  logic [BW-1:0]      bias_q;
  logic [BW-1:0]      bias_mem [DEPTH];

  logic bias_hs, rd_en, last_pop, drain_last, jobs_left;

  assign g_in       = bus.Channel_Out_Num_REG >> 3;
  assign bias_hs    = bus.Bias_Valid && (state == S_LOAD);
  assign rd_en      = (state == S_READ);
  assign last_pop   = (pop_cnt == n_num - 1'b1);
  assign drain_last = (drain_cnt == 4'(ADD_LATENCY));
  assign jobs_left  = (burst_cnt != r_num);

  assign bus.Bias_Ready   = (state == S_LOAD);
  assign bus.rd_en_fifo   = rd_en;
  assign bus.bias_data_in = bias_q;
  assign bus.Next_Reg     = next_q;
  assign bus.M_Valid      = mv_pipe[ADD_LATENCY];
  assign bus.Done         = (state == S_DRAIN) && (zero_job || (drain_last && !jobs_left));

  // Bias memory is not reset; its content is only meaningful after a LOAD.
  always_ff @(posedge clk) begin
    if (bias_hs) bias_mem[load_idx[GW-1:0]] <= bus.Bias_Data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      g_num     <= '0;
      r_num     <= '0;
      n_num     <= '0;
      load_idx  <= '0;
      grp_idx   <= '0;
      pop_cnt   <= '0;
      burst_cnt <= '0;
      drain_cnt <= '0;
      zero_job  <= 1'b0;
      next_q    <= 1'b0;
      mv_pipe   <= '0;
      bias_q    <= '0;
    end else begin
      next_q  <= (state == S_IDLE) && bus.Start;
      mv_pipe <= {mv_pipe[ADD_LATENCY-1:0], rd_en};
      if (rd_en) bias_q <= bias_mem[grp_idx[GW-1:0]];

      case (state)
        S_IDLE: begin
          if (bus.Start) begin
            g_num     <= g_in;
            r_num     <= bus.Row_Num_Out_REG;
            n_num     <= bus.S_Count_Fifo;
            load_idx  <= '0;
            grp_idx   <= '0;
            pop_cnt   <= '0;
            burst_cnt <= '0;
            drain_cnt <= '0;
            // Empty jobs go straight to DRAIN so Done pulses while still busy.
            if (g_in == '0 || bus.Row_Num_Out_REG == '0 || bus.S_Count_Fifo == '0) begin
              zero_job <= 1'b1;
              state    <= S_DRAIN;
            end else begin
              zero_job <= 1'b0;
              state    <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (bias_hs) begin
            load_idx <= load_idx + 1'b1;
            if (load_idx == g_num - 1'b1) state <= S_WAIT;
          end
        end
        S_WAIT: begin
          pop_cnt <= '0;
          if (bus.fifo_ready) state <= S_READ;
        end
        S_READ: begin
          pop_cnt <= pop_cnt + 1'b1;
          grp_idx <= (grp_idx == g_num - 1'b1) ? '0 : grp_idx + 1'b1;
          if (last_pop) begin
            burst_cnt <= burst_cnt + 1'b1;
            drain_cnt <= '0;
            state     <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (zero_job) begin
            zero_job <= 1'b0;
            state    <= S_IDLE;
          end else if (drain_last) begin
            state <= jobs_left ? S_WAIT : S_IDLE;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/conv_bias_ctrl.md
CONV_BIAS_CTRL -- requirements
Module: conv_bias_ctrl

Interface
REQ-001 SHALL have parameter CHANNEL_OUT_NUM, 8, output channels per group; each FIFO word and each bias word carries one group.
REQ-002 SHALL have parameter WIDTH_DATA_ADD, 32, bits per bias value.
REQ-003 SHALL have parameter WIDTH_FEATURE_SIZE, 12, width of the burst-length and row-count registers.
REQ-004 SHALL have parameter WIDTH_CHANNEL_NUM_REG, 10, width of the channel-count register.
REQ-005 SHALL have parameter ADD_LATENCY, 2, adder pipeline depth in cycles, range 1..8.
REQ-006 SHALL have port clk, input, 1, the only clock; all logic rising-edge.
REQ-007 SHALL have port rst, input, 1, reset: asynchronous assert, active-low.
REQ-008 SHALL have port Start, input, 1, one-cycle job start; sampled only in IDLE.
REQ-009 SHALL have port Channel_Out_Num_REG, input, WIDTH_CHANNEL_NUM_REG, output channel count; group count G = value>>3.
REQ-010 SHALL have port Row_Num_Out_REG, input, WIDTH_FEATURE_SIZE, burst count R per job.
REQ-011 SHALL have port S_Count_Fifo, input, WIDTH_FEATURE_SIZE, words per burst N.
REQ-012 SHALL have port Bias_Data, input, WIDTH_DATA_ADD*CHANNEL_OUT_NUM, one bias group (channel j in bits [(j+1)*W-1:j*W]).
REQ-013 SHALL have ports Bias_Valid (input, 1) and Bias_Ready (output, 1), the bias-load handshake.
REQ-014 SHALL have port fifo_ready, input, 1, high when the bias FIFO holds at least N words.
REQ-015 SHALL have port rd_en_fifo, output, 1, FIFO pop strobe; dout is valid one cycle after rd_en_fifo.
REQ-016 SHALL have port bias_data_in, output, WIDTH_DATA_ADD*CHANNEL_OUT_NUM, bias group aligned with FIFO dout.
REQ-017 SHALL have port Next_Reg, output, 1, one-cycle pulse clearing the FIFO at job start.
REQ-018 SHALL have port M_Valid, output, 1, high when the adder sum output is valid.
REQ-019 SHALL have port Done, output, 1, one-cycle pulse at job end.

Function
REQ-020 SHALL latch G, R and N on accepted Start and use only the latched values for the rest of the job.
REQ-021 SHALL implement states IDLE, LOAD, WAIT, READ, DRAIN.
- IDLE->LOAD on Start.
- LOAD->WAIT after G handshakes.
- WAIT->READ when fifo_ready=1.
- READ->DRAIN after N rd_en_fifo cycles.
- DRAIN->WAIT after ADD_LATENCY+1 cycles if bursts remain, else ->IDLE.
REQ-022 SHALL pulse Next_Reg in the cycle after Start is accepted.
REQ-023 SHALL store bias words in an internal G-entry memory of at most 2^(WIDTH_CHANNEL_NUM_REG-3) entries, indexed 0..G-1 in arrival order.
REQ-024 SHALL drive Bias_Ready=1 only in LOAD; a bias word transfers when Bias_Valid and Bias_Ready are both high.
REQ-025 SHALL drive rd_en_fifo=1 on every READ cycle, giving exactly N consecutive pops per burst.
REQ-026 SHALL keep a group index reset to 0 at Start, advanced by 1 per pop, wrapping from G-1 to 0, and continuous across bursts.
REQ-027 SHALL register bias_data_in from memory[group index at pop], so it changes in the cycle dout is valid, and hold it otherwise.
REQ-028 SHALL drive M_Valid as rd_en_fifo delayed by exactly 1+ADD_LATENCY cycles.
REQ-029 SHALL pulse Done in the cycle the DRAIN->IDLE transition occurs, which follows the last M_Valid.
REQ-030 SHALL pulse Done one cycle after Start, without entering LOAD or issuing pops, if G=0, R=0 or N=0.
REQ-031 SHALL ignore Start outside IDLE.
REQ-032 SHALL ignore Bias_Valid outside LOAD.
REQ-033 SHALL give fifo_ready=0 in WAIT indefinite stall with no pops.
REQ-034 SHALL not sample fifo_ready in READ; the burst completes regardless of its value.
REQ-035 SHALL, if Start coincides with the Done pulse, ignore that Start because the state is not yet IDLE.

Reset
REQ-036 SHALL, while rst=0, asynchronously force state IDLE, all counters 0, and Bias_Ready, rd_en_fifo, Next_Reg, M_Valid, Done to 0 and bias_data_in to all-zero.
REQ-037 SHALL, on reset mid-job, abandon the job and clear the delay line with no further M_Valid or Done; bias memory content is undefined until the next LOAD.
REQ-038 SHALL accept Start on the first clk edge after rst deasserts.

Verification
REQ-039 SHALL cover the basic job: Channel_Out_Num_REG=16, R=1, N=4, biases B0,B1, fifo_ready=1 -> 4 pops; bias_data_in sequence B0,B1,B0,B1; M_Valid on pop cycles +3; one Done.
REQ-040 SHALL cover load backpressure: Bias_Valid toggling 1,0,1 with G=2 -> exactly 2 words stored, LOAD exits after the second handshake.
REQ-041 SHALL cover wrap across bursts: G=3, N=2, R=3 -> group index 0,1,2,0,1,2 over 6 pops; 3 WAIT/READ cycles.
REQ-042 SHALL cover stall: fifo_ready held 0 for 20 cycles in WAIT -> no pops; pops start the cycle after fifo_ready=1.
REQ-043 SHALL cover zero config: R=0 -> Done one cycle after Start, Next_Reg pulse, no Bias_Ready.
REQ-044 SHALL cover mid-burst reset: rst=0 at the 2nd pop -> all outputs 0 immediately; a new Start after release runs a normal job.
